// File: rtl/library_bist_ctrl.sv
// rtl/library_bist_ctrl.sv - BIST sequencer for the flop/NAND/NOR/NOT/MUX library cells
// Walks CLR, PRE and eight stimulus vectors, then reports error count and first failure.
module library_bist_ctrl #(
    parameter int HOLD = 3
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic       iQp,
    input  logic       iQn,
    input  logic       iNand,
    input  logic       iNor,
    input  logic       iNot,
    input  logic       iMux,
    output logic       oA,
    output logic       oB,
    output logic       oD,
    output logic       oSel,
    output logic       oEnb,
    output logic       oClr,
    output logic       oPre,
    output logic       oBusy,
    output logic       oDone,
    output logic       oPass,
    output logic [3:0] oErrCnt,
    output logic [3:0] oFailVec,
    output logic [5:0] oFailMask
);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_PRE, S_RUN, S_DONE} state_t;

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic [2:0] vec, next_vec;
    logic       start_ok;
    logic       check;
    logic       fail;
    logic [3:0] chk_id;
    logic [5:0] mask;
    logic [3:0] err_next;
    logic       exp_qp, exp_a, exp_b, exp_sel;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            vec   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            vec   <= next_vec;
        end
    end

    assign start_ok = (state == S_IDLE || state == S_DONE) && iStart;

    always_comb begin
        next_state = state;
        next_cnt   = cnt + 4'd1;
        next_vec   = vec;
        case (state)
            S_IDLE, S_DONE: begin
                next_cnt = 4'd0;
                next_vec = 3'd0;
                if (iStart) next_state = S_CLR;
            end
            S_CLR: if (cnt == 4'd1) begin
                next_state = S_PRE;
                next_cnt   = 4'd0;
            end
            S_PRE: if (cnt == 4'd1) begin
                next_state = S_RUN;
                next_cnt   = 4'd0;
            end
            S_RUN: if (cnt == 4'(HOLD - 1)) begin
                next_cnt = 4'd0;
                next_vec = vec + 3'd1;
                if (vec == 3'd7) next_state = S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Expected responses are derived from the vector index, not from the driven outputs.
    always_comb begin
        exp_a   = vec[1];
        exp_b   = vec[0];
        exp_sel = vec[2];
        exp_qp  = vec[0] ^ vec[2];
        check   = 1'b0;
        chk_id  = {1'b0, vec};
        mask    = 6'd0;
        case (state)
            S_CLR: begin
                check  = (cnt == 4'd1);
                chk_id = 4'd8;
                mask   = {iQp, ~iQn, 4'b0000};
            end
            S_PRE: begin
                check  = (cnt == 4'd1);
                chk_id = 4'd9;
                mask   = {~iQp, iQn, 4'b0000};
            end
            S_RUN: begin
                check = (cnt == 4'(HOLD - 1));
                mask  = {iQp ^ exp_qp, iQn ^ ~exp_qp,
                         iNand ^ ~(exp_a & exp_b), iNor ^ ~(exp_a | exp_b),
                         iNot ^ ~exp_a, iMux ^ (exp_sel ? exp_b : exp_a)};
            end
            default: check = 1'b0;
        endcase
        fail     = check && (mask != 6'd0);
        err_next = (fail && oErrCnt != 4'hF) ? oErrCnt + 4'd1 : oErrCnt;
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oA        <= 1'b0;
            oB        <= 1'b0;
            oD        <= 1'b0;
            oSel      <= 1'b0;
            oEnb      <= 1'b0;
            oClr      <= 1'b1;
            oPre      <= 1'b1;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oPass     <= 1'b0;
            oErrCnt   <= 4'd0;
            oFailVec  <= 4'hF;
            oFailMask <= 6'd0;
        end else begin
            oClr  <= (next_state != S_CLR);
            oPre  <= (next_state != S_PRE);
            oEnb  <= (next_state == S_RUN);
            oA    <= (next_state == S_RUN) && next_vec[1];
            oB    <= (next_state == S_RUN) && next_vec[0];
            oSel  <= (next_state == S_RUN) && next_vec[2];
            oD    <= (next_state == S_RUN) && (next_vec[0] ^ next_vec[2]);
            oBusy <= (next_state == S_CLR || next_state == S_PRE || next_state == S_RUN);
            oDone <= (next_state == S_DONE);
            oPass <= (next_state == S_DONE) && (err_next == 4'd0);
            if (start_ok) begin
                oErrCnt   <= 4'd0;
                oFailVec  <= 4'hF;
                oFailMask <= 6'd0;
            end else begin
                oErrCnt <= err_next;
                if (fail && oFailVec == 4'hF) begin
                    oFailVec  <= chk_id;
                    oFailMask <= mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_library_bist_ctrl.sv
// tb/tb_library_bist_ctrl.sv - scoreboard bench for library_bist_ctrl with faultable cell model
module tb_library_bist_ctrl;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iStart = 1'b0;
    logic       iQp, iQn, iNand, iNor, iNot, iMux;
    logic       oA, oB, oD, oSel, oEnb, oClr, oPre, oBusy, oDone, oPass;
    logic [3:0] oErrCnt, oFailVec;
    logic [5:0] oFailMask;

    logic [1:0] mode = 2'd0;
    logic       q = 1'b0;
    int         edge_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       done_q = 1'b0;

    typedef struct {
        int         edge_n;
        logic [3:0] err;
        logic [3:0] fvec;
        logic [5:0] fmask;
        logic       pass;
    } exp_t;
    exp_t sb[$];

    localparam logic [26:0] RST_VAL = {5'b00000, 2'b11, 3'b000, 4'd0, 4'hF, 6'd0};

    library_bist_ctrl #(.HOLD(3)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart),
        .iQp(iQp), .iQn(iQn), .iNand(iNand), .iNor(iNor), .iNot(iNot), .iMux(iMux),
        .oA(oA), .oB(oB), .oD(oD), .oSel(oSel), .oEnb(oEnb), .oClr(oClr), .oPre(oPre),
        .oBusy(oBusy), .oDone(oDone), .oPass(oPass),
        .oErrCnt(oErrCnt), .oFailVec(oFailVec), .oFailMask(oFailMask)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) edge_cnt <= edge_cnt + 1;

    // Cell model; mode 1 = NAND stuck-1, 2 = MUX select inverted, 3 = flop forced Qp=1/Qn=0
    always @(posedge iClk) begin
        if (!oClr) q <= 1'b0;
        else if (!oPre) q <= 1'b1;
        else if (oEnb) q <= oD;
    end
    assign iQp   = (mode == 2'd3) ? 1'b1 : q;
    assign iQn   = (mode == 2'd3) ? 1'b0 : ~q;
    assign iNand = (mode == 2'd1) ? 1'b1 : ~(oA & oB);
    assign iNor  = ~(oA | oB);
    assign iNot  = ~oA;
    assign iMux  = (mode == 2'd2) ? (oSel ? oA : oB) : (oSel ? oB : oA);

    wire [26:0] all_out = {oA, oB, oD, oSel, oEnb, oClr, oPre, oBusy, oDone, oPass,
                           oErrCnt, oFailVec, oFailMask};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge iClk) begin
        if (oDone && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_edge", edge_cnt, e.edge_n);
                check("err_cnt", {28'd0, oErrCnt}, {28'd0, e.err});
                check("fail_vec", {28'd0, oFailVec}, {28'd0, e.fvec});
                check("fail_mask", {26'd0, oFailMask}, {26'd0, e.fmask});
                check("pass", {31'd0, oPass}, {31'd0, e.pass});
            end
        end
        done_q = oDone;
    end

    task automatic launch(input logic [1:0] m, input bit hold, input bit chk_clear,
                          input logic [3:0] err, input logic [3:0] fvec, input logic [5:0] fmask);
        exp_t e;
        logic busy_bad;
        @(negedge iClk);
        mode   = m;
        iStart = 1'b1;
        e.edge_n = edge_cnt + 1 + 28;
        e.err    = err;
        e.fvec   = fvec;
        e.fmask  = fmask;
        e.pass   = (err == 4'd0);
        sb.push_back(e);
        @(posedge iClk);
        #1;
        if (chk_clear)
            check("clear_at_e0", {5'd0, oBusy, oDone, oPass, oErrCnt, oFailVec, oFailMask},
                  {5'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 6'd0});
        busy_bad = 1'b0;
        for (int k = 0; k < 28; k++) begin
            @(negedge iClk);
            if (!oBusy) busy_bad = 1'b1;
            if ((!hold && k == 0) || (hold && k == 20)) iStart = 1'b0;
        end
        check("busy_window", {31'd0, busy_bad}, 32'd0);
        @(negedge iClk);
        check("busy_low_done", {30'd0, oBusy, oDone}, 32'd1);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge iClk);
        check("scoreboard_drained", sb.size(), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge iClk);
        check("reset_in_reset", {5'd0, all_out}, {5'd0, RST_VAL});
        iRst = 1'b0;
        repeat (2) @(negedge iClk);
        check("idle_after_reset", {5'd0, all_out}, {5'd0, RST_VAL});

        launch(2'd0, 1'b1, 1'b0, 4'd0, 4'hF, 6'b000000);
        launch(2'd1, 1'b0, 1'b0, 4'd2, 4'd3, 6'b001000);
        launch(2'd2, 1'b0, 1'b0, 4'd4, 4'd1, 6'b000001);
        launch(2'd0, 1'b0, 1'b1, 4'd0, 4'hF, 6'b000000);
        launch(2'd3, 1'b0, 1'b0, 4'd5, 4'd8, 6'b110000);

        // Abort mid-RUN with an asynchronous reset between clock edges.
        @(negedge iClk);
        mode   = 2'd0;
        iStart = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iStart = 1'b0;
        repeat (9) @(posedge iClk);
        #2;
        check("run_before_abort", {31'd0, oEnb}, 32'd1);
        iRst = 1'b1;
        #1;
        check("async_reset", {5'd0, all_out}, {5'd0, RST_VAL});
        @(negedge iClk);
        iRst = 1'b0;
        repeat (5) @(negedge iClk);
        check("stay_idle", {5'd0, all_out}, {5'd0, RST_VAL});

        launch(2'd0, 1'b0, 1'b0, 4'd0, 4'hF, 6'b000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #60000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
